// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the multi-cycle core: opcodes, load/store funct3
// encodings, data-memory responder state type and load-data extension helper.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_t;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
        logic [7:0]  b;
        logic [15:0] h;
        case (offset)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      load_extend = {{24{b[7]}}, b};
            LH:      load_extend = {{16{h[15]}}, h};
            LW:      load_extend = word;
            LBU:     load_extend = {24'h0, b};
            LHU:     load_extend = {16'h0, h};
            default: load_extend = '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word array with per-byte write enables and a
// registered read port; contents are not reset.
module dmem_sram #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per request, WAIT_STATES extra cycles,
// one-cycle ready pulse. Define DMEM_MISALIGN_TRAP_EN for the err trap port.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  f3_q;
    logic        store_q;

    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_f3;
    logic        cur_store, cur_bad;
    logic        accept, enter_resp, we;
    logic [3:0]  be;
    logic [31:0] lane_data, sram_q, load_val;
    logic        unused_bits;

    // In IDLE the live inputs feed the array so a zero-wait access can hit it on the accept edge.
    always_comb begin
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_f3    = f3_q;
        cur_store = store_q;
        if (state == DMEM_IDLE) begin
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_f3    = funct3;
            cur_store = memwrite;
        end
    end

    assign accept = (state == DMEM_IDLE) && (memread || memwrite);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            DMEM_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = DMEM_RESP;
                    end else begin
                        state_next = DMEM_WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            DMEM_WAIT: begin
                if (cnt == '0) state_next = DMEM_RESP;
                else           cnt_next   = cnt - 4'd1;
            end
            default: state_next = DMEM_IDLE;
        endcase
    end

    assign enter_resp = (state_next == DMEM_RESP) && (state != DMEM_RESP);

    always_comb begin
        if (cur_store) cur_bad = !(cur_f3 inside {SB, SH, SW});
        else           cur_bad = !(cur_f3 inside {LB, LH, LW, LBU, LHU});
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((cur_f3[1:0] == 2'b01 && cur_addr[0]) ||
            (cur_f3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00)) begin
            cur_bad = 1'b1;
        end
`endif
    end

    always_comb begin
        be        = '0;
        lane_data = cur_wdata;
        case (cur_f3)
            SB: begin
                be        = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            SH: begin
                be        = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            SW:      be = '1;
            default: be = '0;
        endcase
    end

    assign we = enter_resp && cur_store && !cur_bad;

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk  (clk),
        .addr (cur_addr[AW+1:2]),
        .we   (we),
        .be   (be),
        .wdata(lane_data),
        .rdata(sram_q)
    );

    assign load_val = cur_bad ? '0 : load_extend(sram_q, cur_f3, cur_addr[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DMEM_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                f3_q    <= funct3;
                store_q <= memwrite;
            end
            if (state == DMEM_RESP && !store_q) begin
                rdata_q <= load_val;
            end
        end
    end

    // The array read is registered, so during RESP a load's word is presented
    // directly and captured into rdata_q on the way back to IDLE.
    assign rdata = (state == DMEM_RESP && !store_q) ? load_val : rdata_q;
    assign ready = (state == DMEM_RESP);
    assign busy  = (state != DMEM_IDLE);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign err   = ready && cur_bad;
`endif

    assign unused_bits = ^cur_addr[31:AW+2];

endmodule
